mem_port_arbiter: RTL

Round-robin arbiter that shares port B of the memory map (external memory plus memory-mapped I/O above 0x01FF) among up to `NUM_REQ` requesters, e.g. display reader, I/O controller, loader. It accepts one access per cycle, drives the port's address, write-data and write-enable from registers, and returns read data with a per-requester valid strobe. The CPU keeps exclusive use of port A; this block owns port B only.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port B among NUM_REQ requesters, with a
// registered issue stage and a 2-cycle read-return tag pipeline.
// Optional burst lock when MEM_ARB_BURST_LOCK_EN is defined.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data,
  output logic                             mem_write,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic [PW-1:0]         gidx_next;
  logic                  found;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_we;
  logic [NUM_REQ-1:0]    rtag;

  // Handshake: requester i presents req[i] with addr/we/wdata held stable;
  // the access transfers on the rising edge where req[i] & gnt[i]. gnt is
  // combinational, so the next request may follow in the very next cycle.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign accept    = found & reset;
  assign gidx_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);

  always_comb begin
    gnt      = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && gidx == PW'(i)) begin
        gnt[i]   = 1'b1;
        sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we   = we[i];
      end
    end
  end

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam int CW = 5;

  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] eff_cnt;
  logic          hold;

  // A grant to anyone other than the current pointer owner starts a fresh burst.
  always_comb begin
    eff_cnt = (gidx == ptr) ? burst_cnt : '0;
    hold    = accept & lock[gidx] & (eff_cnt < CW'(MAX_BURST - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      if (hold) begin
        ptr       <= gidx;
        burst_cnt <= eff_cnt + CW'(1);
      end else begin
        ptr       <= gidx_next;
        burst_cnt <= '0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = (^lock) ^ (MAX_BURST > 0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= gidx_next;
    end
  end
`endif

  // Issue stage drives port B one cycle after acceptance; rtag marks reads so
  // rvalid lines up with the synchronous RAM output two cycles after accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      rtag      <= '0;
      rvalid    <= '0;
    end else begin
      mem_write <= accept & sel_we;
      if (accept) begin
        mem_addr <= sel_addr;
        mem_data <= sel_data;
      end
      rtag   <= gnt & ~we;
      rvalid <= rtag;
    end
  end

  assign rdata = mem_rdata;

endmodule
